// File: rtl/alu_operand_stage.sv
// Registered ALU operand-select pipeline slice: picks one of NUM_SRC sources,
// applies EX/MEM forwarding to the register-file source, and holds the result behind a valid/ready handshake.
module alu_operand_stage #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int REG_SRC = 0,
  parameter int FWD_EN  = 1,
  localparam int SELW   = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_SRC*WIDTH-1:0] src_bus,
  input  logic [SELW-1:0]          sel,
  input  logic [4:0]               rs_addr,
  input  logic                     ex_wr_en,
  input  logic [4:0]               ex_rd,
  input  logic [WIDTH-1:0]         ex_result,
  input  logic                     mem_wr_en,
  input  logic [4:0]               mem_rd,
  input  logic [WIDTH-1:0]         mem_result,
  input  logic                     stall,
  input  logic                     flush,
  output logic [WIDTH-1:0]         operand,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               fwd_src,
  output logic                     sel_err,
  output logic [15:0]              fwd_count
);

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EX   = 2'd1,
    FWD_MEM  = 2'd2
  } fwd_e;

  logic [WIDTH-1:0] operand_q, operand_d;
  logic             out_valid_q;
  fwd_e             fwd_src_q, fwd_src_d;
  logic             sel_err_q;
  logic [15:0]      fwd_count_q;
  logic             sel_ok;
  logic             accept;

  assign in_ready = !stall && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    operand_d = '0;
    sel_ok    = 1'b0;
    fwd_src_d = FWD_NONE;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SELW'(k)) begin
        operand_d = src_bus[k*WIDTH +: WIDTH];
        sel_ok    = 1'b1;
      end
    end
    // x0 is hardwired zero, so a pending write to it must never be forwarded.
    if (FWD_EN != 0 && sel == SELW'(REG_SRC) && rs_addr != 5'd0) begin
      if (ex_wr_en && ex_rd == rs_addr) begin
        operand_d = ex_result;
        fwd_src_d = FWD_EX;
      end else if (mem_wr_en && mem_rd == rs_addr) begin
        operand_d = mem_result;
        fwd_src_d = FWD_MEM;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  // NOTE: every register, including the operand data, is reset so no stale value survives rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_q   <= '0;
      out_valid_q <= 1'b0;
      fwd_src_q   <= FWD_NONE;
      sel_err_q   <= 1'b0;
      fwd_count_q <= '0;
    end else if (flush) begin
      operand_q   <= '0;
      out_valid_q <= 1'b0;
      fwd_src_q   <= FWD_NONE;
    end else if (accept) begin
      operand_q   <= operand_d;
      out_valid_q <= 1'b1;
      fwd_src_q   <= fwd_src_d;
      if (!sel_ok) sel_err_q <= 1'b1;
      if (fwd_src_d != FWD_NONE && fwd_count_q != 16'hFFFF) fwd_count_q <= fwd_count_q + 16'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign operand   = operand_q;
  assign out_valid = out_valid_q;
  assign fwd_src   = fwd_src_q;
  assign sel_err   = sel_err_q;
  assign fwd_count = fwd_count_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed plan steps plus random traffic
// compared against a behavioural model of the stage.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] src [4];
  logic [127:0] src_bus;
  logic [1:0]  sel;
  logic [4:0]  rs_addr, ex_rd, mem_rd;
  logic        ex_wr_en, mem_wr_en;
  logic [31:0] ex_result, mem_result;
  logic        stall, flush, out_ready;
  logic [31:0] operand;
  logic        out_valid;
  logic [1:0]  fwd_src;
  logic        sel_err;
  logic [15:0] fwd_count;

  logic        in_valid3, in_ready3;
  logic [1:0]  sel3;
  logic [31:0] operand3;
  logic        out_valid3;
  logic [1:0]  fwd_src3;
  logic        sel_err3;
  logic [15:0] fwd_count3;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic        m_valid;
  logic [31:0] m_op;
  int          m_fwd;
  logic        m_err;
  int          m_cnt;

  always #5 clk = ~clk;
  always_comb src_bus = {src[3], src[2], src[1], src[0]};

  alu_operand_stage u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .src_bus(src_bus), .sel(sel), .rs_addr(rs_addr),
    .ex_wr_en(ex_wr_en), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_result(mem_result),
    .stall(stall), .flush(flush), .operand(operand), .out_valid(out_valid),
    .out_ready(out_ready), .fwd_src(fwd_src), .sel_err(sel_err), .fwd_count(fwd_count)
  );

  alu_operand_stage #(.WIDTH(32), .NUM_SRC(3), .REG_SRC(0), .FWD_EN(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .src_bus(src_bus[95:0]), .sel(sel3), .rs_addr(rs_addr),
    .ex_wr_en(ex_wr_en), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_result(mem_result),
    .stall(stall), .flush(flush), .operand(operand3), .out_valid(out_valid3),
    .out_ready(out_ready), .fwd_src(fwd_src3), .sel_err(sel_err3), .fwd_count(fwd_count3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_op = '0; m_fwd = 0; m_err = 1'b0; m_cnt = 0;
  endtask

  function automatic bit model_ready();
    return !stall && (!m_valid || out_ready);
  endfunction

  // Applies the stage rules for one rising edge, using the inputs held across it.
  task automatic model_edge();
    bit rdy;
    rdy = model_ready();
    if (flush) begin
      m_valid = 1'b0; m_fwd = 0; m_op = '0;
    end else if (in_valid && rdy) begin
      if (sel == 2'd0 && rs_addr != 0 && ex_wr_en && ex_rd == rs_addr) begin
        m_op = ex_result; m_fwd = 1;
      end else if (sel == 2'd0 && rs_addr != 0 && mem_wr_en && mem_rd == rs_addr) begin
        m_op = mem_result; m_fwd = 2;
      end else begin
        m_op = src[sel]; m_fwd = 0;
      end
      if (m_fwd != 0 && m_cnt < 65535) m_cnt = m_cnt + 1;
      m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle();
    #2;
    check("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
    @(posedge clk);
    model_edge();
    #1;
    check("operand", operand, m_op);
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("fwd_src", {30'd0, fwd_src}, 32'(m_fwd));
    check("sel_err", {31'd0, sel_err}, {31'd0, m_err});
    check("fwd_count", {16'd0, fwd_count}, 32'(m_cnt));
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_valid3 = 0; sel = 0; sel3 = 0; rs_addr = 0;
    ex_wr_en = 0; ex_rd = 0; ex_result = 0; mem_wr_en = 0; mem_rd = 0; mem_result = 0;
    stall = 0; flush = 0; out_ready = 1;
    for (int k = 0; k < 4; k++) src[k] = 32'h1000_0000 + k;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;

    // 1. Reset
    #12;
    check("rst_operand", operand, 32'h0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sel_err", {31'd0, sel_err}, 32'd0);
    check("rst_fwd_count", {16'd0, fwd_count}, 32'd0);
    check("rst_fwd_src", {30'd0, fwd_src}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2. Plain select
    sel = 2; in_valid = 1; cycle();
    check("plain_operand", operand, 32'h1000_0002);
    check("plain_valid", {31'd0, out_valid}, 32'd1);
    check("plain_fwd", {30'd0, fwd_src}, 32'd0);

    // 3. Forward priority
    sel = 0; rs_addr = 5; ex_wr_en = 1; ex_rd = 5; ex_result = 32'hAAAA_0001;
    mem_wr_en = 1; mem_rd = 5; mem_result = 32'hBBBB_0002;
    cycle();
    check("fwd_ex_operand", operand, 32'hAAAA_0001);
    check("fwd_ex_src", {30'd0, fwd_src}, 32'd1);
    ex_wr_en = 0; cycle();
    check("fwd_mem_operand", operand, 32'hBBBB_0002);
    check("fwd_mem_src", {30'd0, fwd_src}, 32'd2);
    rs_addr = 0; ex_wr_en = 1; ex_rd = 0; mem_rd = 0; cycle();
    check("x0_operand", operand, 32'h1000_0000);
    check("x0_src", {30'd0, fwd_src}, 32'd0);
    check("fwd_count_two", {16'd0, fwd_count}, 32'd2);
    ex_wr_en = 0; mem_wr_en = 0;

    // 4. Backpressure, then no-bubble replacement
    src[1] = 32'hDEAD_BEEF; sel = 1; cycle();
    out_ready = 0; sel = 2;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_hold_operand", operand, 32'hDEAD_BEEF);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1; cycle();
    check("bp_new_operand", operand, 32'h1000_0002);
    check("bp_new_valid", {31'd0, out_valid}, 32'd1);

    // 5. Stall and flush
    stall = 1; sel = 3; cycle();
    check("stall_drained", {31'd0, out_valid}, 32'd0);
    check("stall_operand_kept", operand, 32'h1000_0002);
    stall = 0; flush = 1; sel = 0; rs_addr = 7; ex_wr_en = 1; ex_rd = 7; ex_result = 32'h1234_5678;
    cycle();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_count", {16'd0, fwd_count}, 32'd2);
    flush = 0; ex_wr_en = 0; in_valid = 0; cycle();

    // 6a. Out-of-range select on the three-source instance
    in_valid3 = 1; sel3 = 3; cycle();
    check("err_operand3", operand3, 32'h0);
    check("err_valid3", {31'd0, out_valid3}, 32'd1);
    check("err_sticky3", {31'd0, sel_err3}, 32'd1);
    sel3 = 1; cycle();
    check("ok_operand3", operand3, src[1]);
    check("err_still3", {31'd0, sel_err3}, 32'd1);
    in_valid3 = 0; cycle();
    check("err_held3", {31'd0, sel_err3}, 32'd1);
    check("dut3_count", {16'd0, fwd_count3}, 32'd0);

    // 6b. fwd_count saturation
    in_valid = 1; sel = 0; rs_addr = 9; ex_wr_en = 1; ex_rd = 9;
    for (int i = 0; i < 65537; i++) begin
      ex_result = i;
      cycle();
    end
    check("sat_count", {16'd0, fwd_count}, 32'h0000_FFFF);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      sel       = 2'($urandom_range(3));
      rs_addr   = 5'($urandom_range(3));
      ex_wr_en  = $urandom_range(1);
      ex_rd     = 5'($urandom_range(3));
      ex_result = $urandom;
      mem_wr_en = $urandom_range(1);
      mem_rd    = 5'($urandom_range(3));
      mem_result = $urandom;
      stall     = ($urandom_range(4) == 0);
      flush     = ($urandom_range(9) == 0);
      out_ready = ($urandom_range(2) != 0);
      for (int k = 0; k < 4; k++) src[k] = $urandom;
      cycle();
    end

    // Reset mid-transfer drops the held operand immediately
    idle_inputs();
    in_valid = 1; sel = 3; out_ready = 0; cycle();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_operand", operand, 32'h0);
    check("midrst_count", {16'd0, fwd_count}, 32'd0);
    check("midrst_err3", {31'd0, sel_err3}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    in_valid = 0;
    @(posedge clk); #1;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Parametrised, registered ALU operand-select stage for the pipelined OTTER datapath. Selects one of NUM_SRC operand sources; register sources take EX/MEM forwarding. The result is latched into an ID/EX-style output register with a valid/ready handshake, stall and flush. It generalises the single-cycle combinational source-B mux into a pipeline slice usable for either ALU operand.

Parameters:
WIDTH, 32, operand/data width in bits
NUM_SRC, 4, number of selectable sources (2..16); SELW = max(1, clog2(NUM_SRC))
REG_SRC, 0, index of the source that reads the register file and is subject to forwarding
FWD_EN, 1, 1 = forwarding enabled; 0 = forwarding logic removed, fwd_* outputs tied 0

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream presents an operand request
in_ready  out  1  stage can accept this cycle
src_bus  in  NUM_SRC*WIDTH  packed sources; source k = src_bus[k*WIDTH +: WIDTH]
sel  in  SELW  source select
rs_addr  in  5  register index of REG_SRC operand
ex_wr_en  in  1  EX stage will write rd
ex_rd  in  5  EX destination register
ex_result  in  WIDTH  EX result
mem_wr_en  in  1  MEM stage will write rd
mem_rd  in  5  MEM destination register
mem_result  in  WIDTH  MEM result
stall  in  1  hazard unit freezes this stage
flush  in  1  branch/jump squash
operand  out  WIDTH  registered selected operand
out_valid  out  1  operand valid
out_ready  in  1  downstream accepts operand
fwd_src  out  2  registered forward source of held operand: 0 none, 1 EX, 2 MEM
sel_err  out  1  sticky: an out-of-range sel was accepted
fwd_count  out  16  saturating count of accepted forwarded operands

Behaviour:
- Reset (rst_n=0, asynchronous): operand=0, out_valid=0, fwd_src=0, sel_err=0, fwd_count=0.
- in_ready = !stall && (!out_valid || out_ready). Combinational; does not depend on in_valid.
- Accept = in_valid && in_ready. On accept, next-edge operand = selected value; out_valid=1; fwd_src updated. Latency 1 cycle.
- Selection: sel < NUM_SRC gives source sel. sel >= NUM_SRC gives operand 0 and sets sel_err (sticky until reset).
- Forwarding applies only when FWD_EN=1, sel==REG_SRC and rs_addr!=0.
- EX match (ex_wr_en && ex_rd==rs_addr) uses ex_result, fwd_src=1.
- Otherwise MEM match (mem_wr_en && mem_rd==rs_addr) uses mem_result, fwd_src=2.
- Otherwise the raw source is used, fwd_src=0. EX has priority over MEM when both match.
- rs_addr==0 never forwards, even if ex_rd==0 with ex_wr_en=1.
- Hold: out_valid && !out_ready with no flush keeps operand, fwd_src and out_valid stable.
- Drain: out_valid && out_ready && no accept clears out_valid next edge. Operand keeps its last value.
- Back-to-back: out_ready=1 and accept in the same cycle replaces the operand; out_valid stays 1 (full throughput).
- Stall: in_ready=0 and no accept. An already-valid output still drains on out_ready.
- Flush: wins over everything except reset. Next edge out_valid=0, fwd_src=0, and no accept occurs even if in_valid && in_ready. Operand data is don't-care; the implementation clears it to 0.
- fwd_count increments on each accept with fwd_src≠0. It saturates at 16'hFFFF.
- Reset mid-transfer drops any held operand immediately; no partial state survives.

Test Plan:
1. Reset: hold rst_n=0 then release → operand=0, out_valid=0, sel_err=0, fwd_count=0. in_ready=1 when stall=0.
2. Plain select: src k = 32'h1000_0000+k, sel=2, in_valid=1, out_ready=1 → next cycle operand=32'h1000_0002, out_valid=1, fwd_src=0.
3. Forward priority: sel=REG_SRC, rs_addr=5, both stages write x5, ex_result=32'hAAAA_0001, mem_result=32'hBBBB_0002 → operand=32'hAAAA_0001, fwd_src=1. Drop ex_wr_en → 32'hBBBB_0002, fwd_src=2. rs_addr=0 with ex_rd=0 → raw source, fwd_src=0.
4. Backpressure: out_ready=0 for 3 cycles after a valid operand 32'hDEAD_BEEF → operand stable, in_ready=0. Raise out_ready with a new request → 32'hDEAD_BEEF is consumed, and the new operand appears the next cycle with no bubble.
5. Stall/flush: stall=1 with in_valid=1 → no accept. flush=1 together with accept → out_valid=0 next edge, fwd_count unchanged.
6. Error/saturation: NUM_SRC=3, sel=3 → operand=0, sel_err=1, which stays 1 afterwards. Preload fwd_count near 16'hFFFF via 65535+2 forwarded accepts → count holds at 16'hFFFF.
